subtractor_4bit_serial: RTL and testbench

Bit-serial 4-bit subtractor computing A − B − Bin one bit per clock, LSB first, through a single registered borrow stage. It is the subtraction counterpart to the 4-bit ripple-carry adder in the arithmetic parts library. It trades four cycles of latency for a one-bit datapath, and exposes a Start/Busy/Done handshake. It is used by sequential datapaths (compare, decrement, ALU sub path) that can tolerate multi-cycle results.

---
 rtl/subtractor_4bit_serial_if.sv | 23 ++
 rtl/subtractor_4bit_serial.sv | 98 +++++++++
 tb/tb_subtractor_4bit_serial.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/subtractor_4bit_serial_if.sv
// Start/Busy/Done handshake and operand/result bundle
// for the bit-serial 4-bit subtractor.
interface subtractor_4bit_serial_if;
   logic       Start;
   logic [3:0] A;
   logic [3:0] B;
   logic       Bin;
   logic [3:0] Diff;
   logic       Bout;
   logic       V;
   logic       Busy;
   logic       Done;

   modport master (
      output Start, A, B, Bin,
      input  Diff, Bout, V, Busy, Done
   );

   modport slave (
      input  Start, A, B, Bin,
      output Diff, Bout, V, Busy, Done
   );
endinterface

// File: rtl/subtractor_4bit_serial.sv
// Bit-serial A - B - Bin, LSB first, one bit per clock
// through a single registered borrow; results land on Done.
module subtractor_4bit_serial (
   input logic                   clk,
   input logic                   rst,
   subtractor_4bit_serial_if.slave bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t     r_state;
   state_t     w_next;
   logic       w_cap;
   logic       w_last;

   logic [3:0] r_a;
   logic [3:0] r_b;
   logic       r_br;
   logic [1:0] r_idx;
   logic [3:0] r_sh;
   logic [3:0] r_diff;
   logic       r_bout;
   logic       r_v;
   logic       r_done;

   logic       w_ai;
   logic       w_bi;
   logic       w_d;
   logic       w_brn;

   assign w_ai  = r_a[r_idx];
   assign w_bi  = r_b[r_idx];
   assign w_d   = w_ai ^ w_bi ^ r_br;
   assign w_brn = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);

   always_comb begin
      w_next = r_state;
      w_cap  = 1'b0;
      w_last = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.Start) begin
               w_next = RUN;
               w_cap  = 1'b1;
            end
         end
         RUN: begin
            if (r_idx == 2'd3) begin
               w_next = IDLE;
               w_last = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_a     <= 4'h0;
         r_b     <= 4'h0;
         r_br    <= 1'b0;
         r_idx   <= 2'd0;
         r_sh    <= 4'h0;
         r_diff  <= 4'h0;
         r_bout  <= 1'b0;
         r_v     <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= w_last;
         if (w_cap) begin
            r_a   <= bus.A;
            r_b   <= bus.B;
            r_br  <= bus.Bin;
            r_idx <= 2'd0;
            r_sh  <= 4'h0;
         end else if (r_state == RUN) begin
            r_sh  <= {w_d, r_sh[3:1]};
            r_br  <= w_brn;
            r_idx <= r_idx + 2'd1;
            // last step: publish the assembled word, never the partial one
            if (w_last) begin
               r_diff <= {w_d, r_sh[3:1]};
               r_bout <= w_brn;
               r_v    <= (r_a[3] != r_b[3]) && (w_d != r_a[3]);
            end
         end
      end
   end

   assign bus.Diff = r_diff;
   assign bus.Bout = r_bout;
   assign bus.V    = r_v;
   assign bus.Busy = (r_state == RUN);
   assign bus.Done = r_done;

endmodule

// File: tb/tb_subtractor_4bit_serial.sv
// Directed and exhaustive bench for the serial subtractor;
// expected results are queued at Start and checked on Done.
module tb_subtractor_4bit_serial;

   typedef struct packed {
      logic [3:0] diff;
      logic       bout;
      logic       v;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   n_done;
   logic prev_done;
   exp_t q[$];

   subtractor_4bit_serial_if sif ();

   subtractor_4bit_serial dut (
      .clk (clk),
      .rst (rst),
      .bus (sif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(
      input logic [3:0] a,
      input logic [3:0] b,
      input logic       bin
   );
      exp_t m;
      int   u;
      int   sa;
      int   sb;
      int   r;
      u      = int'(a) - int'(b) - int'(bin);
      m.diff = u[3:0];
      m.bout = (u < 0);
      sa     = a[3] ? int'(a) - 16 : int'(a);
      sb     = b[3] ? int'(b) - 16 : int'(b);
      r      = sa - sb - int'(bin);
      m.v    = (r > 7) || (r < -8);
      return m;
   endfunction

   task automatic check(
      input string tag,
      input int    obs,
      input int    exp
   );
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // scoreboard side: every Done must match the oldest queued result
   always @(negedge clk) begin
      exp_t e;
      if (sif.Done) begin
         n_done++;
         if (prev_done) check("done_width", 2, 1);
         if (q.size() == 0) begin
            check("spurious_done", 1, 0);
         end else begin
            e = q.pop_front();
            check("diff", int'(sif.Diff), int'(e.diff));
            check("bout", int'(sif.Bout), int'(e.bout));
            check("v", int'(sif.V), int'(e.v));
         end
      end
      prev_done = sif.Done;
   end

   task automatic run_op(
      input logic [3:0] a,
      input logic [3:0] b,
      input logic       bin
   );
      int nb;
      int guard;
      @(negedge clk);
      sif.A     = a;
      sif.B     = b;
      sif.Bin   = bin;
      sif.Start = 1'b1;
      q.push_back(model(a, b, bin));
      @(posedge clk);
      #1;
      sif.Start = 1'b0;
      nb    = 0;
      guard = 0;
      while (sif.Busy && guard < 16) begin
         nb++;
         @(posedge clk);
         #1;
         guard++;
      end
      check("busy_cycles", nb, 4);
      check("done_at_n4", int'(sif.Done), 1);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (q.size() != 0 && guard < 40) begin
         @(posedge clk);
         guard++;
      end
      check("drain", q.size(), 0);
   endtask

   initial begin
      int d0;
      n_checks  = 0;
      n_errors  = 0;
      n_done    = 0;
      prev_done = 1'b0;
      rst       = 1'b1;
      sif.Start = 1'b1;
      sif.A     = 4'h7;
      sif.B     = 4'h2;
      sif.Bin   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(sif.Busy), 0);
      check("rst_done", int'(sif.Done), 0);
      check("rst_diff", int'(sif.Diff), 0);
      check("rst_bout", int'(sif.Bout), 0);
      check("rst_v", int'(sif.V), 0);
      @(negedge clk);
      sif.Start = 1'b0;
      rst       = 1'b0;

      run_op(4'd9, 4'd3, 1'b0);
      run_op(4'd3, 4'd9, 1'b0);
      run_op(4'd0, 4'd0, 1'b1);
      run_op(4'd8, 4'd1, 1'b0);
      drain();

      // Start held high, operands changing every cycle
      d0 = n_done;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 0) begin
            sif.A   = 4'd5;
            sif.B   = 4'd2;
            sif.Bin = 1'b0;
         end else begin
            sif.A   = 4'($urandom_range(0, 15));
            sif.B   = 4'($urandom_range(0, 15));
            sif.Bin = 1'($urandom_range(0, 1));
         end
         sif.Start = 1'b1;
         if (k % 5 == 0) q.push_back(model(sif.A, sif.B, sif.Bin));
      end
      @(negedge clk);
      sif.Start = 1'b0;
      drain();
      check("b2b_dones", n_done - d0, 4);

      // reset on the second bit step aborts the operation
      d0 = n_done;
      @(negedge clk);
      sif.A     = 4'd15;
      sif.B     = 4'd1;
      sif.Bin   = 1'b0;
      sif.Start = 1'b1;
      @(posedge clk);
      #1;
      sif.Start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_busy", int'(sif.Busy), 0);
      check("abort_diff", int'(sif.Diff), 0);
      check("abort_bout", int'(sif.Bout), 0);
      check("abort_v", int'(sif.V), 0);
      repeat (8) @(posedge clk);
      check("abort_no_done", n_done - d0, 0);
      run_op(4'd15, 4'd1, 1'b0);
      drain();

      // exhaustive sweep
      for (int i = 0; i < 512; i++) begin
         logic [8:0] w;
         w = 9'(i);
         run_op(w[3:0], w[7:4], w[8]);
      end
      drain();
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
